// File: rtl/alu_serial_exec_if.sv
// rtl/alu_serial_exec_if.sv - start/result handshake bundle for alu_serial_exec
//
// Signals:
//   start_valid, start_ready          operation request handshake
//   ALUControl[2:0], SrcA, SrcB       opcode and operands, sampled on the accepting edge
//   result_valid, result_ready        result handshake
//   ALUResult, Zero, Illegal          registered result and flags, held until the next completion
//   Carry, Overflow, Negative         extra flags, present only with ALU_SERIAL_FLAGS_EN
// Modports: master drives requests and consumes results; slave is the ALU.
interface alu_serial_exec_if #(
    parameter int WIDTH = 32
) ();
    logic             start_valid;
    logic             start_ready;
    logic [2:0]       ALUControl;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             result_valid;
    logic             result_ready;
    logic [WIDTH-1:0] ALUResult;
    logic             Zero;
    logic             Illegal;
`ifdef ALU_SERIAL_FLAGS_EN
    logic             Carry;
    logic             Overflow;
    logic             Negative;
`endif

    modport master (
        output start_valid, ALUControl, SrcA, SrcB, result_ready,
`ifdef ALU_SERIAL_FLAGS_EN
        input  Carry, Overflow, Negative,
`endif
        input  start_ready, result_valid, ALUResult, Zero, Illegal
    );

    modport slave (
        input  start_valid, ALUControl, SrcA, SrcB, result_ready,
`ifdef ALU_SERIAL_FLAGS_EN
        output Carry, Overflow, Negative,
`endif
        output start_ready, result_valid, ALUResult, Zero, Illegal
    );
endinterface

// File: rtl/alu_serial_exec.sv
// rtl/alu_serial_exec.sv - digit-serial ALU (add/sub/and/or/slt), DIGIT bits per cycle, LSB first
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    alu_serial_exec_if.slave (start/result handshakes, operands, result, flags)
// Parameters: WIDTH operand width (multiple of DIGIT), DIGIT bits per BUSY cycle.
// Optional: define ALU_SERIAL_FLAGS_EN to add Carry/Overflow/Negative outputs.
module alu_serial_exec #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    alu_serial_exec_if.slave  bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b101;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, next_state;
    logic [WIDTH-1:0] a_q, b_q, res_sh;
    logic [2:0]       op_q;
    logic             carry_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] alu_result_q;
    logic             zero_q, illegal_q;
    logic             start_ready, result_valid;

    logic             last_digit, b_inv, op_illegal, v_dig;
    logic [DIGIT-1:0] a_dig, b_dig, dig_res;
    logic [DIGIT:0]   dsum;
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic [WIDTH-1:0] res_next, final_res;

    assign last_digit = (count_q == CW'(N - 1));
    assign b_inv      = (op_q == OP_SUB) || (op_q == OP_SLT);
    assign op_illegal = (op_q == 3'b100) || (op_q == 3'b110) || (op_q == 3'b111);

    // Subtraction is A + ~B + 1: B is inverted per digit, the +1 comes from the
    // carry preset on accept.
    assign a_dig = a_q[DIGIT-1:0];
    assign b_dig = b_inv ? ~b_q[DIGIT-1:0] : b_q[DIGIT-1:0];
    assign dsum  = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};

    // Carry into the digit MSB equals a^b^sum at that bit, so overflow falls
    // out of the top bit without a separate lower-bits adder.
    assign v_dig = a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ dsum[DIGIT-1] ^ dsum[DIGIT];

    always_comb begin
        dig_res = dsum[DIGIT-1:0];
        if (op_q == OP_AND) begin
            dig_res = a_q[DIGIT-1:0] & b_q[DIGIT-1:0];
        end else if (op_q == OP_OR) begin
            dig_res = a_q[DIGIT-1:0] | b_q[DIGIT-1:0];
        end
    end

    // New digit enters at the top; after N digits the LSB digit sits at the bottom.
    assign res_cat  = {dig_res, res_sh};
    assign res_next = res_cat[WIDTH+DIGIT-1:DIGIT];

    always_comb begin
        final_res = res_next;
        if (op_illegal) begin
            final_res = '0;
        end else if (op_q == OP_SLT) begin
            final_res = {{(WIDTH-1){1'b0}}, dsum[DIGIT-1] ^ v_dig};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    always_comb begin
        next_state   = state_q;
        start_ready  = 1'b0;
        result_valid = 1'b0;
        case (state_q)
            IDLE: begin
                start_ready = 1'b1;
                if (bus.start_valid) begin
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (last_digit) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                result_valid = 1'b1;
                if (bus.result_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

`ifdef ALU_SERIAL_FLAGS_EN
    logic carry_fq, overflow_fq, negative_fq;
    logic is_arith;
    assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            carry_fq    <= 1'b0;
            overflow_fq <= 1'b0;
            negative_fq <= 1'b0;
        end else if (state_q == BUSY && last_digit) begin
            carry_fq    <= is_arith & dsum[DIGIT];
            overflow_fq <= is_arith & v_dig;
            negative_fq <= final_res[WIDTH-1];
        end
    end

    assign bus.Carry    = carry_fq;
    assign bus.Overflow = overflow_fq;
    assign bus.Negative = negative_fq;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q          <= '0;
            b_q          <= '0;
            res_sh       <= '0;
            op_q         <= OP_ADD;
            carry_q      <= 1'b0;
            count_q      <= '0;
            alu_result_q <= '0;
            zero_q       <= 1'b1;
            illegal_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start_valid) begin
                        a_q     <= bus.SrcA;
                        b_q     <= bus.SrcB;
                        op_q    <= bus.ALUControl;
                        carry_q <= (bus.ALUControl == OP_SUB) || (bus.ALUControl == OP_SLT);
                        count_q <= '0;
                    end
                end
                BUSY: begin
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    res_sh  <= res_next;
                    carry_q <= dsum[DIGIT];
                    count_q <= count_q + CW'(1);
                    if (last_digit) begin
                        alu_result_q <= final_res;
                        zero_q       <= (final_res == '0);
                        illegal_q    <= op_illegal;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.start_ready  = start_ready;
    assign bus.result_valid = result_valid;
    assign bus.ALUResult    = alu_result_q;
    assign bus.Zero         = zero_q;
    assign bus.Illegal      = illegal_q;
endmodule

// File: tb/tb_alu_serial_exec.sv
// tb/tb_alu_serial_exec.sv - self-checking bench for alu_serial_exec
module tb_alu_serial_exec;
    localparam int N = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_serial_exec_if #(.WIDTH(32)) bus ();

    alu_serial_exec #(.WIDTH(32), .DIGIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int tests = 0;
    int fails = 0;

    logic        exp_ready = 1'b1;
    logic        exp_valid = 1'b0;
    logic [31:0] exp_result = 32'd0;
    logic        exp_zero = 1'b1;
    logic        exp_illegal = 1'b0;
`ifdef ALU_SERIAL_FLAGS_EN
    logic        exp_c = 1'b0, exp_v = 1'b0, exp_n = 1'b0;
`endif

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_res(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b101:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic model_illegal(input logic [2:0] c);
        return (c == 3'b100) || (c == 3'b110) || (c == 3'b111);
    endfunction

    // Compare process: outputs are registered and held, so all are meaningful every cycle.
    always @(negedge clk) begin
        check1("start_ready", bus.start_ready, exp_ready);
        check1("result_valid", bus.result_valid, exp_valid);
        check32("ALUResult", bus.ALUResult, exp_result);
        check1("Zero", bus.Zero, exp_zero);
        check1("Illegal", bus.Illegal, exp_illegal);
`ifdef ALU_SERIAL_FLAGS_EN
        check1("Carry", bus.Carry, exp_c);
        check1("Overflow", bus.Overflow, exp_v);
        check1("Negative", bus.Negative, exp_n);
`endif
    end

    task automatic set_expect(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        exp_result  = model_res(c, a, b);
        exp_zero    = (exp_result == 32'd0);
        exp_illegal = model_illegal(c);
`ifdef ALU_SERIAL_FLAGS_EN
        begin
            logic [32:0] wide;
            logic [31:0] bb;
            bb    = (c == 3'b001) ? ~b : b;
            wide  = {1'b0, a} + {1'b0, bb} + {32'd0, (c == 3'b001)};
            exp_c = (c == 3'b000 || c == 3'b001) ? wide[32] : 1'b0;
            exp_v = (c == 3'b000 || c == 3'b001) ?
                    ((a[31] == bb[31]) && (wide[31] != a[31])) : 1'b0;
            exp_n = exp_result[31];
        end
`endif
    endtask

    // One full operation: accept, N busy edges, optional stall in DONE, handshake.
    task automatic run_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                          input int stall, input bit poke_busy, input logic [31:0] lit);
        bus.start_valid = 1'b1;
        bus.ALUControl  = c;
        bus.SrcA        = a;
        bus.SrcB        = b;
        @(posedge clk); #1;
        bus.start_valid  = 1'b0;
        bus.ALUControl   = 3'($urandom_range(0, 7));
        bus.SrcA         = $urandom;
        bus.SrcB         = $urandom;
        bus.result_ready = (stall == 0);
        exp_ready = 1'b0;
        for (int i = 1; i < N; i++) begin
            bus.start_valid = poke_busy && (i >= 2) && (i <= 5);
            @(posedge clk); #1;
        end
        bus.start_valid = 1'b0;
        @(posedge clk); #1;
        exp_valid = 1'b1;
        set_expect(c, a, b);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
        end
        bus.result_ready = 1'b1;
        @(posedge clk); #1;
        exp_valid = 1'b0;
        exp_ready = 1'b1;
        check32("lit_result", bus.ALUResult, lit);
        check1("lit_zero", bus.Zero, (lit == 32'd0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1);
    end

    initial begin
        bus.start_valid  = 1'b0;
        bus.ALUControl   = 3'b000;
        bus.SrcA         = 32'd0;
        bus.SrcB         = 32'd0;
        bus.result_ready = 1'b1;
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check1("rst_start_ready", bus.start_ready, 1'b1);
        check1("rst_result_valid", bus.result_valid, 1'b0);
        check32("rst_ALUResult", bus.ALUResult, 32'd0);
        check1("rst_Zero", bus.Zero, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;

        run_op(3'b000, 32'd5, 32'd7, 0, 1'b0, 32'h0000000C);
        run_op(3'b001, 32'd3, 32'd5, 0, 1'b0, 32'hFFFFFFFE);
        run_op(3'b001, 32'h1234, 32'h1234, 0, 1'b0, 32'h00000000);
        run_op(3'b101, 32'hFFFFFFFF, 32'h00000001, 0, 1'b0, 32'h00000001);
        run_op(3'b101, 32'h7FFFFFFF, 32'h80000000, 0, 1'b0, 32'h00000000);
        run_op(3'b101, 32'h80000000, 32'h7FFFFFFF, 0, 1'b0, 32'h00000001);
        run_op(3'b101, 32'd5, 32'd5, 0, 1'b0, 32'h00000000);
        run_op(3'b000, 32'hFFFFFFFF, 32'h00000001, 0, 1'b0, 32'h00000000);
        run_op(3'b010, 32'hF0F0F0F0, 32'hFF00FF00, 0, 1'b0, 32'hF000F000);
        run_op(3'b011, 32'hF0F0F0F0, 32'hFF00FF00, 5, 1'b1, 32'hFFF0FFF0);

        // Reset during BUSY at count 3 aborts with no result.
        bus.start_valid = 1'b1;
        bus.ALUControl  = 3'b000;
        bus.SrcA        = 32'd9;
        bus.SrcB        = 32'd9;
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        exp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset       = 1'b0;
        exp_ready   = 1'b1;
        exp_valid   = 1'b0;
        exp_result  = 32'd0;
        exp_zero    = 1'b1;
        exp_illegal = 1'b0;
`ifdef ALU_SERIAL_FLAGS_EN
        exp_c = 1'b0; exp_v = 1'b0; exp_n = 1'b0;
`endif
        #1;
        check1("abort_start_ready", bus.start_ready, 1'b1);
        check1("abort_result_valid", bus.result_valid, 1'b0);
        check32("abort_ALUResult", bus.ALUResult, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        run_op(3'b000, 32'd1, 32'd1, 0, 1'b0, 32'h00000002);

        run_op(3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0, 32'h00000000);
        check1("lit_illegal", bus.Illegal, 1'b1);
        run_op(3'b100, 32'h00000010, 32'h00000020, 2, 1'b0, 32'h00000000);
        run_op(3'b000, 32'h12345678, 32'h11111111, 0, 1'b0, 32'h23456789);
        check1("lit_legal_again", bus.Illegal, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_serial_exec.md
Name: alu_serial_exec

Overview:
- Multi-cycle, digit-serial ALU for the multicycle RISC-V datapath.
- Consumes the 3-bit ALUControl code produced by the ALU decoder and executes it on two operands, DIGIT bits per clock, LSB first.
- Start and result use valid/ready handshakes, so the controller FSM can stall on either side.
- Output feeds ALUOut/branch logic through ALUResult and Zero.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per BUSY cycle; N = WIDTH/DIGIT is the number of BUSY cycles (8 at defaults).

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- start_valid  input  1  operation request.
- start_ready  output  1  block can accept a request.
- ALUControl  input  3  000 add, 001 sub, 010 and, 011 or, 101 slt; others are illegal.
- SrcA  input  WIDTH  operand A.
- SrcB  input  WIDTH  operand B.
- result_valid  output  1  result available.
- result_ready  input  1  consumer takes result.
- ALUResult  output  WIDTH  result.
- Zero  output  1  ALUResult == 0.
- Illegal  output  1  the completed op used an unsupported code.

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE, start_ready=1, result_valid=0, ALUResult=0, Zero=1, Illegal=0.
  - Internal operand/shift registers, carry and counter are cleared.
  - Reset mid-operation aborts the op with no result.
- States IDLE, BUSY, DONE. start_ready is 1 only in IDLE, so there is no overlap of operations.
- IDLE:
  - On start_valid & start_ready at an edge, latch SrcA, SrcB and ALUControl; count=0; go to BUSY.
  - Carry-in = 1 for sub/slt (B is inverted during processing), 0 otherwise.
  - No computation happens on the accept edge.
  - ALUControl, SrcA and SrcB are don't-care after acceptance.
- BUSY:
  - Each edge combines the low DIGIT bits of A and B, shifts the digit result into the result register from the top, shifts A and B right by DIGIT, and updates carry.
  - add/sub use ripple add with carry; and/or are bitwise.
  - After the N-th BUSY edge (count==N-1), go to DONE.
- Timing: result_valid rises exactly N cycles after the accepting edge (8 at defaults).
- slt: the full subtraction A-B is computed serially, with carry into the MSB captured during the last digit.
  - Final ALUResult = {WIDTH-1 zeros, N xor V}, signed compare.
  - N = MSB of the difference; V = carry-into-MSB xor carry-out.
  - The slt result is written on the final BUSY edge.
- Illegal codes (100, 110, 111): the op runs the full N cycles, ALUResult=0, Zero=1, Illegal=1.
- Arithmetic is modulo 2^WIDTH; carry-out is discarded for add/sub.
- DONE:
  - result_valid=1. ALUResult, Zero and Illegal are held stable while result_ready=0, for unlimited backpressure.
  - On result_valid & result_ready, go to IDLE; outputs keep their last values until the next completion.
  - The earliest new accept is the cycle after the result handshake.
- Zero and Illegal are registered together with ALUResult and update only on entry to DONE.

Optional Feature:
- Macro ALU_SERIAL_FLAGS_EN.
- When defined, add outputs Carry (1), Overflow (1) and Negative (1), registered on entry to DONE and held like ALUResult.
  - add/sub: Carry = carry-out, Overflow = signed overflow, Negative = result MSB.
  - Other ops: Carry=0, Overflow=0, Negative = ALUResult MSB.
  - All three reset to 0.
- When undefined, these ports and their flops are absent; all other behaviour is identical.

Test Plan:
- add 5+7, result_ready=1 -> result_valid exactly 8 cycles after accept, ALUResult=0x0000000C, Zero=0, Illegal=0; back in IDLE the next cycle.
- sub 3-5 -> 0xFFFFFFFE; sub 0x1234-0x1234 -> 0x00000000, Zero=1.
- slt 0xFFFFFFFF vs 0x00000001 -> 1.
- slt 0x7FFFFFFF vs 0x80000000 -> 0 (overflow case).
- and 0xF0F0F0F0 with 0xFF00FF00 -> 0xF000F000.
- or of the same operands -> 0xFFF0FFF0.
- Backpressure: result_ready=0 for 5 cycles in DONE -> outputs stable and start_ready=0 throughout; start_valid during BUSY is ignored.
- Reset pulled low at BUSY count 3 -> immediate IDLE, result_valid=0, ALUResult=0; a new add 1+1 afterwards -> 2.
- Illegal code 3'b111 with A=B=0xFFFFFFFF -> ALUResult=0, Zero=1, Illegal=1 after 8 cycles.
